sram_port_arbiter: RTL and testbench

- Shares one single-port SRAM word interface (1-cycle read latency, always ready) between NumReq requesters, e.g. the AXI-to-mem bridge and a DMA/debug port.
- Arbitrates round-robin, issues at most one SRAM access per cycle, and routes the response back to the originator.
- Also sequences SRAM retention: enters retention after an idle timeout and runs a timed wake-up before granting again.
- Sits between the requester-side mem interfaces and the sram_wrapper instance in the memory subsystem.

---
 rtl/core_v_mcu_pkg.sv | 25 ++
 rtl/sram_port_arbiter_rr.sv | 41 ++++
 rtl/sram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_v_mcu_pkg.sv
// -----------------------------------------------------------------------------
// core_v_mcu_pkg
//   Types and constants shared by the memory subsystem.
//   - sram_arb_state_e : power/arbitration state of sram_port_arbiter
//   - SramAddrWidth    : SRAM word address width
//   - SramDataWidth    : SRAM data width in bits
//   - wrap_inc()       : modulo-n increment used for round-robin pointers
// -----------------------------------------------------------------------------
package core_v_mcu_pkg;

  localparam int unsigned SramAddrWidth = 13;
  localparam int unsigned SramDataWidth = 64;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    RETENTION = 2'd1,
    WAKE      = 2'd2
  } sram_arb_state_e;

  // (idx + 1) mod n, for idx < n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter_comb
//   Stateless round-robin picker: grants the first set request at or after
//   ptr_i, wrapping modulo NumReq. The pointer register lives in the caller.
//   Ports:
//     req_i   [NumReq] request vector
//     ptr_i   [IdxW]   highest-priority index this cycle
//     gnt_o   [NumReq] one-hot grant (all zero when nothing requests)
//     idx_o   [IdxW]   index of the granted requester (0 when none)
//     valid_o          a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter_comb #(
  parameter  int unsigned NumReq = 2,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              valid_o
);

  always_comb begin
    logic [IdxW-1:0] k;
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, so no path can leave it unassigned (no latch).
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      k = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one single-port SRAM (1-cycle read latency, always ready) between
//   NumReq requesters. Round-robin, at most one access per cycle, response
//   routed back to the originator one cycle after its grant. Also sequences
//   SRAM retention: after IdleCycles idle cycles (with ret_en_i) the SRAM is
//   put into retention; any request or ret_en_i dropping starts a WakeCycles
//   wake-up before grants resume.
//   Ports:
//     clk_i, rst_i           clock, asynchronous active-high reset
//     req_i/we_i             per-requester request / write enable
//     addr_i/wdata_i/be_i    per-requester fields, requester k at slice k
//     gnt_o                  one-hot grant, same cycle as the request
//     rvalid_o/rdata_o       response one cycle after grant; rdata shared
//     ret_en_i               allow entering retention
//     mem_*                  SRAM side; mem_set_retentive_no low = retention
//     busy_o                 not ACTIVE, or a response is still pending
// -----------------------------------------------------------------------------
module sram_port_arbiter
  import core_v_mcu_pkg::*;
#(
  parameter int unsigned NumReq     = 2,
  parameter int unsigned AddrWidth  = SramAddrWidth,
  parameter int unsigned DataWidth  = SramDataWidth,
  parameter int unsigned IdleCycles = 64,
  parameter int unsigned WakeCycles = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  input  logic                          ret_en_i,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  output logic [DataWidth/8-1:0]        mem_be_o,
  input  logic [DataWidth-1:0]          mem_rdata_i,
  output logic                          mem_set_retentive_no,
  output logic                          busy_o
);

  localparam int unsigned IdxW    = $clog2(NumReq);
  localparam int unsigned BeWidth = DataWidth / 8;
  localparam int unsigned IdleW   = $clog2(IdleCycles + 1);
  localparam int unsigned WakeW   = $clog2(WakeCycles + 1);

  sram_arb_state_e state_q, state_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
  logic             pend_q, pend_d;
  logic [IdxW-1:0]  win_q, win_d;
  logic             ret_no_q, ret_no_d;

  logic              grant_en;
  logic [NumReq-1:0] arb_req;
  logic [NumReq-1:0] arb_gnt;
  logic [IdxW-1:0]   arb_idx;
  logic              arb_valid;
  logic              idle;

  // Grants only in ACTIVE, and never while reset is held so the grant and
  // mem_* outputs show their reset values even if requesters are driving.
  assign grant_en = (state_q == ACTIVE) && !rst_i;
  assign arb_req  = grant_en ? req_i : '0;

  rr_arbiter_comb #(
    .NumReq (NumReq)
  ) u_rr_arbiter (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Request side: mux the winner's fields onto the SRAM port.
  assign gnt_o       = arb_gnt;
  assign mem_req_o   = arb_valid;
  assign mem_we_o    = arb_valid & we_i[arb_idx];
  assign mem_addr_o  = addr_i[arb_idx*AddrWidth +: AddrWidth];
  assign mem_wdata_o = wdata_i[arb_idx*DataWidth +: DataWidth];
  assign mem_be_o    = be_i[arb_idx*BeWidth +: BeWidth];

  // Response side: one-hot rvalid for the registered winner; rdata is shared.
  always_comb begin
    rvalid_o = '0;
    if (pend_q) rvalid_o[win_q] = 1'b1;
  end

  assign rdata_o              = mem_rdata_i;
  assign mem_set_retentive_no = ret_no_q;
  assign busy_o               = (state_q != ACTIVE) || pend_q;

  // Idle means nothing requesting and no response still in flight, so the
  // SRAM can never enter retention with a read outstanding.
  assign idle = (req_i == '0) && !pend_q;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    pend_d     = arb_valid;
    win_d      = arb_valid ? arb_idx : win_q;
    ptr_d      = arb_valid ? IdxW'(wrap_inc(32'(arb_idx), NumReq)) : ptr_q;

    case (state_q)
      ACTIVE: begin
        // The counter holds IdleCycles for one cycle before leaving ACTIVE;
        // a request in that cycle makes it non-idle and is granted instead.
        if (!ret_en_i || !idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleW'(IdleCycles)) begin
          state_d    = RETENTION;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      RETENTION: begin
        if ((req_i != '0) || !ret_en_i) begin
          state_d    = WAKE;
          wake_cnt_d = '0;
        end
      end
      WAKE: begin
        if (wake_cnt_q == WakeW'(WakeCycles - 1)) begin
          state_d    = ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = ACTIVE;
    endcase

    // Registered so the retention pin changes exactly with the state.
    ret_no_d = (state_d != RETENTION);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ACTIVE;
      ptr_q      <= '0;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      pend_q     <= 1'b0;
      win_q      <= '0;
      ret_no_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge value of every other register, independent of statement order.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      pend_q     <= pend_d;
      win_q      <= win_d;
      ret_no_q   <= ret_no_d;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//   Directed bench for sram_port_arbiter (NumReq=2, default widths/timers).
//   Inputs change just after the falling edge; outputs are sampled 1 time unit
//   later, well away from the rising edge. A small SRAM model with 1-cycle read
//   latency sits on the mem_* port.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int unsigned NumReq = 2;
  localparam int unsigned AW     = 13;
  localparam int unsigned DW     = 64;
  localparam int unsigned BW     = DW / 8;

  localparam logic [63:0] D0 = 64'hDEADBEEF_00000001;
  localparam logic [63:0] D1 = 64'hFFFFFFFF_00000000;
  localparam logic [63:0] D2 = 64'h01234567_89ABCDEF;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NumReq-1:0]      req;
  logic [NumReq-1:0]      we;
  logic [NumReq*AW-1:0]   addr;
  logic [NumReq*DW-1:0]   wdata;
  logic [NumReq*BW-1:0]   be;
  logic                   ret_en;
  logic [NumReq-1:0]      gnt_o;
  logic [NumReq-1:0]      rvalid_o;
  logic [DW-1:0]          rdata_o;
  logic                   mem_req_o;
  logic                   mem_we_o;
  logic [AW-1:0]          mem_addr_o;
  logic [DW-1:0]          mem_wdata_o;
  logic [BW-1:0]          mem_be_o;
  logic [DW-1:0]          mem_rdata = '0;
  logic                   mem_set_retentive_no;
  logic                   busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .NumReq     (NumReq),
    .AddrWidth  (AW),
    .DataWidth  (DW),
    .IdleCycles (64),
    .WakeCycles (4)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .req_i                (req),
    .we_i                 (we),
    .addr_i               (addr),
    .wdata_i              (wdata),
    .be_i                 (be),
    .gnt_o                (gnt_o),
    .rvalid_o             (rvalid_o),
    .rdata_o              (rdata_o),
    .ret_en_i             (ret_en),
    .mem_req_o            (mem_req_o),
    .mem_we_o             (mem_we_o),
    .mem_addr_o           (mem_addr_o),
    .mem_wdata_o          (mem_wdata_o),
    .mem_be_o             (mem_be_o),
    .mem_rdata_i          (mem_rdata),
    .mem_set_retentive_no (mem_set_retentive_no),
    .busy_o               (busy_o)
  );

  // SRAM model: byte-masked writes, reads return one cycle later.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < BW; b++)
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr_o];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [BW-1:0] b);
    req[k]            = 1'b1;
    we[k]             = w;
    addr[k*AW +: AW]  = a;
    wdata[k*DW +: DW] = d;
    be[k*BW +: BW]    = b;
  endtask

  task automatic idle_all();
    req = '0;
    we  = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    int         n0;
    int         n1;
    logic       seen_low;

    rst    = 1'b1;
    req    = '0;
    we     = '0;
    addr   = '0;
    wdata  = '0;
    be     = '0;
    ret_en = 1'b0;
    prev_g = '0;
    n0     = 0;
    n1     = 0;

    // ---- reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt",    64'(gnt_o), 64'h0);
    check("rst_rvalid", 64'(rvalid_o), 64'h0);
    check("rst_memreq", 64'(mem_req_o), 64'h0);
    check("rst_memwe",  64'(mem_we_o), 64'h0);
    check("rst_retno",  64'(mem_set_retentive_no), 64'h1);
    check("rst_busy",   64'(busy_o), 64'h0);
    rst = 1'b0;

    // ---- single write then read, requester 0
    @(negedge clk);
    put(0, 1'b1, 13'h010, D0, 8'hFF);
    #1;
    check("wr_gnt",   64'(gnt_o), 64'h1);
    check("wr_req",   64'(mem_req_o), 64'h1);
    check("wr_we",    64'(mem_we_o), 64'h1);
    check("wr_addr",  64'(mem_addr_o), 64'h010);
    check("wr_wdata", mem_wdata_o, D0);
    check("wr_be",    64'(mem_be_o), 64'hFF);
    @(negedge clk);
    put(0, 1'b0, 13'h010, '0, '0);
    #1;
    check("rd_gnt",       64'(gnt_o), 64'h1);
    check("rd_we",        64'(mem_we_o), 64'h0);
    check("wr_rvalid",    64'(rvalid_o), 64'h1);
    @(negedge clk);
    idle_all();
    #1;
    check("rd_rvalid", 64'(rvalid_o), 64'h1);
    check("rd_rdata",  rdata_o, D0);
    check("rd_nognt",  64'(gnt_o), 64'h0);
    @(negedge clk);
    #1;
    check("rd_rvalid_off", 64'(rvalid_o), 64'h0);

    // ---- byte enables, requester 1
    @(negedge clk);
    put(1, 1'b1, 13'h020, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
    #1;
    check("be_gnt1", 64'(gnt_o), 64'h2);
    @(negedge clk);
    put(1, 1'b1, 13'h020, 64'h0, 8'h0F);
    #1;
    check("be_gnt2", 64'(gnt_o), 64'h2);
    check("be_mask", 64'(mem_be_o), 64'h0F);
    @(negedge clk);
    put(1, 1'b0, 13'h020, '0, '0);
    #1;
    check("be_gnt3", 64'(gnt_o), 64'h2);
    @(negedge clk);
    idle_all();
    #1;
    check("be_rvalid", 64'(rvalid_o), 64'h2);
    check("be_rdata",  rdata_o, D1);

    // ---- contention: both read continuously for 8 cycles, pointer at 0
    @(negedge clk);
    put(0, 1'b0, 13'h010, '0, '0);
    put(1, 1'b0, 13'h020, '0, '0);
    for (int i = 0; i < 8; i++) begin
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("cont_gnt", 64'(gnt_o), 64'(exp_g));
      if (i > 0) begin
        check("cont_rvalid", 64'(rvalid_o), 64'(prev_g));
        check("cont_rdata", rdata_o, prev_g[0] ? D0 : D1);
      end
      if (gnt_o[0]) n0++;
      if (gnt_o[1]) n1++;
      prev_g = exp_g;
      @(negedge clk);
    end
    idle_all();
    #1;
    check("cont_rvalid_last", 64'(rvalid_o), 64'(prev_g));
    check("cont_rdata_last",  rdata_o, D1);
    check("cont_count0", 64'(n0), 64'd4);
    check("cont_count1", 64'(n1), 64'd4);

    // ---- reset asserted in the cycle after a grant
    @(negedge clk);
    put(0, 1'b0, 13'h010, '0, '0);
    #1;
    check("rstrd_gnt", 64'(gnt_o), 64'h1);
    @(posedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle_all();
    #1;
    check("rstrd_rvalid", 64'(rvalid_o), 64'h0);
    check("rstrd_gnt0",   64'(gnt_o), 64'h0);
    check("rstrd_memreq", 64'(mem_req_o), 64'h0);
    check("rstrd_memwe",  64'(mem_we_o), 64'h0);
    check("rstrd_retno",  64'(mem_set_retentive_no), 64'h1);
    check("rstrd_busy",   64'(busy_o), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstrd_rvalid_rel", 64'(rvalid_o), 64'h0);
    @(negedge clk);
    put(1, 1'b0, 13'h010, '0, '0);
    #1;
    check("postrst_gnt", 64'(gnt_o), 64'h2);
    @(negedge clk);
    idle_all();
    #1;
    check("postrst_rvalid", 64'(rvalid_o), 64'h2);
    check("postrst_rdata",  rdata_o, D0);

    // ---- ret_en_i low: 1000 idle cycles never enter retention
    seen_low = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (!mem_set_retentive_no) seen_low = 1'b1;
    end
    check("noret_retno", 64'(seen_low), 64'h0);
    check("noret_busy",  64'(busy_o), 64'h0);

    // ---- retention after 64 counted idle cycles, then a timed wake
    @(negedge clk);
    ret_en = 1'b1;
    repeat (64) @(negedge clk);
    #1;
    check("ret_before", 64'(mem_set_retentive_no), 64'h1);
    @(negedge clk);
    #1;
    check("ret_entered", 64'(mem_set_retentive_no), 64'h0);
    check("ret_busy",    64'(busy_o), 64'h1);
    put(0, 1'b0, 13'h020, '0, '0);
    #1;
    check("ret_gnt_blocked", 64'(gnt_o), 64'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("wake_gnt",   64'(gnt_o), 64'h0);
      check("wake_retno", 64'(mem_set_retentive_no), 64'h1);
      check("wake_busy",  64'(busy_o), 64'h1);
    end
    @(negedge clk);
    #1;
    check("wake_done_gnt", 64'(gnt_o), 64'h1);
    @(negedge clk);
    idle_all();
    #1;
    check("wake_rvalid", 64'(rvalid_o), 64'h1);
    check("wake_rdata",  rdata_o, D1);
    check("wake_busy_pend", 64'(busy_o), 64'h1);

    // ---- request in the exact cycle the idle counter holds IdleCycles
    ret_en = 1'b0;
    repeat (2) @(negedge clk);
    ret_en = 1'b1;
    repeat (64) @(negedge clk);
    put(0, 1'b1, 13'h030, D2, 8'hFF);
    #1;
    check("coll_gnt",   64'(gnt_o), 64'h1);
    check("coll_retno", 64'(mem_set_retentive_no), 64'h1);
    @(negedge clk);
    idle_all();
    #1;
    check("coll_rvalid",  64'(rvalid_o), 64'h1);
    check("coll_retno2",  64'(mem_set_retentive_no), 64'h1);
    @(negedge clk);
    put(1, 1'b0, 13'h030, '0, '0);
    #1;
    check("coll_retno3", 64'(mem_set_retentive_no), 64'h1);
    check("coll_rd_gnt", 64'(gnt_o), 64'h2);
    @(negedge clk);
    idle_all();
    #1;
    check("coll_rd_rvalid", 64'(rvalid_o), 64'h2);
    check("coll_rd_rdata",  rdata_o, D2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
